// File: rtl/gb_audio_mixer_n.sv
// gb_audio_mixer_n: mixes N stereo Gameboy audio sources into one stereo pair.
// A sample_ce strobe snapshots all inputs, then one channel is accumulated per
// cycle (N cycles), and the result is scaled/saturated and registered.
// Optional per-channel attenuation: define GB_MIX_VOLUME_EN to add the vol port.
module gb_audio_mixer_n #(
    parameter int N = 2,
    parameter int W = 16,
    localparam int CW = $clog2(N),
    localparam int AW = W + $clog2(N)
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            sample_ce,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   sel_a,
    input  logic [CW-1:0]   sel_b,
    input  logic [N-1:0]    ch_en,
    input  logic [N*W-1:0]  audio_l_in,
    input  logic [N*W-1:0]  audio_r_in,
`ifdef GB_MIX_VOLUME_EN
    input  logic [N*4-1:0]  vol,
`endif
    output logic [W-1:0]    audio_l,
    output logic [W-1:0]    audio_r,
    output logic            out_valid,
    output logic            busy,
    output logic            overrun
);

    // Accumulators carry one spare bit so SPLIT (l+r) can never overflow.
    localparam int ACC = AW + 1;
    localparam int SH  = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    localparam logic [1:0] MODE_SOLO    = 2'd0;
    localparam logic [1:0] MODE_SPLIT   = 2'd1;
    localparam logic [1:0] MODE_MIX_SAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [N*W-1:0]    snap_l_reg;
    logic [N*W-1:0]    snap_r_reg;
    logic [1:0]        mode_reg;
    logic [CW-1:0]     sel_a_reg;
    logic [CW-1:0]     sel_b_reg;
    logic [N-1:0]      en_reg;
`ifdef GB_MIX_VOLUME_EN
    logic [N*4-1:0]    vol_reg;
`endif
    logic [CW-1:0]     idx_reg;
    logic [ACC-1:0]    acc_l_reg;
    logic [ACC-1:0]    acc_r_reg;
    logic [W-1:0]      audio_l_reg;
    logic [W-1:0]      audio_r_reg;
    logic              overrun_reg;

    // Per-channel samples after optional attenuation, taken from the snapshot.
    logic [W-1:0]      chan_l [N];
    logic [W-1:0]      chan_r [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
`ifdef GB_MIX_VOLUME_EN
            assign chan_l[gi] = snap_l_reg[gi*W +: W] >> vol_reg[gi*4 +: 4];
            assign chan_r[gi] = snap_r_reg[gi*W +: W] >> vol_reg[gi*4 +: 4];
`else
            assign chan_l[gi] = snap_l_reg[gi*W +: W];
            assign chan_r[gi] = snap_r_reg[gi*W +: W];
`endif
        end
    endgenerate

    logic [ACC-1:0]    ext_l;
    logic [ACC-1:0]    ext_r;
    logic [ACC-1:0]    ext_lr;
    logic [ACC-1:0]    add_l;
    logic [ACC-1:0]    add_r;
    logic [ACC-1:0]    sum_l;
    logic [ACC-1:0]    sum_r;

    // Scale the final accumulator to W bits according to the routing mode.
    function automatic logic [W-1:0] finalize(input logic [1:0] m, input logic [ACC-1:0] a);
        logic [W-1:0] res;
        case (m)
            MODE_SOLO:    res = a[W-1:0];
            MODE_SPLIT:   res = a[W:1];
            MODE_MIX_SAT: res = (|a[ACC-1:W]) ? {W{1'b1}} : a[W-1:0];
            default:      res = a[W+SH-1:SH];
        endcase
        return res;
    endfunction

    // Select what the current channel contributes to each side this cycle.
    always_comb begin
        ext_l  = {{(ACC-W){1'b0}}, chan_l[idx_reg]};
        ext_r  = {{(ACC-W){1'b0}}, chan_r[idx_reg]};
        ext_lr = ext_l + ext_r;
        add_l  = '0;
        add_r  = '0;
        case (mode_reg)
            MODE_SOLO: begin
                if (idx_reg == sel_a_reg) begin
                    add_l = ext_l;
                    add_r = ext_r;
                end
            end
            MODE_SPLIT: begin
                if (idx_reg == sel_a_reg) add_l = ext_lr;
                if (idx_reg == sel_b_reg) add_r = ext_lr;
            end
            default: begin
                if (en_reg[idx_reg]) begin
                    add_l = ext_l;
                    add_r = ext_r;
                end
            end
        endcase
        sum_l = acc_l_reg + add_l;
        sum_r = acc_r_reg + add_r;
    end

    // State register; reset aborts any mix in progress.
    always_ff @(posedge clk_sys) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: IDLE -> ACCUM (N cycles) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (sample_ce) state_next = ST_ACCUM;
            ST_ACCUM: if (idx_reg == LAST_IDX) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Snapshot, accumulation and output registers. Outputs are loaded on the
    // edge that enters DONE so they are valid during the out_valid cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            snap_l_reg  <= '0;
            snap_r_reg  <= '0;
            mode_reg    <= '0;
            sel_a_reg   <= '0;
            sel_b_reg   <= '0;
            en_reg      <= '0;
`ifdef GB_MIX_VOLUME_EN
            vol_reg     <= '0;
`endif
            idx_reg     <= '0;
            acc_l_reg   <= '0;
            acc_r_reg   <= '0;
            audio_l_reg <= '0;
            audio_r_reg <= '0;
            overrun_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sample_ce) begin
                        snap_l_reg <= audio_l_in;
                        snap_r_reg <= audio_r_in;
                        mode_reg   <= mode;
                        sel_a_reg  <= sel_a;
                        sel_b_reg  <= sel_b;
                        en_reg     <= ch_en;
`ifdef GB_MIX_VOLUME_EN
                        vol_reg    <= vol;
`endif
                        idx_reg    <= '0;
                        acc_l_reg  <= '0;
                        acc_r_reg  <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc_l_reg <= sum_l;
                    acc_r_reg <= sum_r;
                    if (idx_reg == LAST_IDX) begin
                        audio_l_reg <= finalize(mode_reg, sum_l);
                        audio_r_reg <= finalize(mode_reg, sum_r);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
            if (sample_ce && (state_reg != ST_IDLE)) overrun_reg <= 1'b1;
        end
    end

    assign audio_l   = audio_l_reg;
    assign audio_r   = audio_r_reg;
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_gb_audio_mixer_n.sv
// Testbench for gb_audio_mixer_n: N=2 and N=4 instances, scoreboard-checked.
module tb_gb_audio_mixer_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        ce2, ce4;
    logic [1:0]  mode;
    logic [1:0]  sel_a, sel_b;
    logic [3:0]  ch_en;
    logic [63:0] l_in, r_in;
    logic [15:0] vol_in;

    logic [15:0] a_l2, a_r2, a_l4, a_r4;
    logic        ov2, busy2, orun2, ov4, busy4, orun4;

    gb_audio_mixer_n #(.N(2), .W(16)) dut2 (
        .clk_sys(clk), .reset(rst), .sample_ce(ce2), .mode(mode),
        .sel_a(sel_a[0:0]), .sel_b(sel_b[0:0]), .ch_en(ch_en[1:0]),
        .audio_l_in(l_in[31:0]), .audio_r_in(r_in[31:0]),
`ifdef GB_MIX_VOLUME_EN
        .vol(vol_in[7:0]),
`endif
        .audio_l(a_l2), .audio_r(a_r2), .out_valid(ov2), .busy(busy2), .overrun(orun2)
    );

    gb_audio_mixer_n #(.N(4), .W(16)) dut4 (
        .clk_sys(clk), .reset(rst), .sample_ce(ce4), .mode(mode),
        .sel_a(sel_a), .sel_b(sel_b), .ch_en(ch_en),
        .audio_l_in(l_in), .audio_r_in(r_in),
`ifdef GB_MIX_VOLUME_EN
        .vol(vol_in),
`endif
        .audio_l(a_l4), .audio_r(a_r4), .out_valid(ov4), .busy(busy4), .overrun(orun4)
    );

    typedef struct {
        int l;
        int r;
        int due;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    exp_t m2, m4;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nv2 = 0;
    int   nv4 = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference mixer: straightforward arithmetic on the channel values.
    function automatic exp_t model(input int n, input int md, input int sa, input int sb,
                                   input int en, input logic [63:0] lp, input logic [63:0] rp,
                                   input logic [15:0] vp);
        int   l[4];
        int   r[4];
        int   sl;
        int   sr;
        exp_t e;
        sl = 0;
        sr = 0;
        for (int i = 0; i < 4; i++) begin
            l[i] = 0;
            r[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            l[i] = int'(lp[i*16 +: 16] >> vp[i*4 +: 4]);
            r[i] = int'(rp[i*16 +: 16] >> vp[i*4 +: 4]);
        end
        case (md)
            0: if (sa < n) begin sl = l[sa]; sr = r[sa]; end
            1: begin
                if (sa < n) sl = (l[sa] + r[sa]) / 2;
                if (sb < n) sr = (l[sb] + r[sb]) / 2;
            end
            default: begin
                for (int i = 0; i < n; i++)
                    if (en[i]) begin sl += l[i]; sr += r[i]; end
                if (md == 2) begin
                    if (sl > 65535) sl = 65535;
                    if (sr > 65535) sr = 65535;
                end else begin
                    sl = sl / n;
                    sr = sr / n;
                end
            end
        endcase
        e.l = sl;
        e.r = sr;
        e.due = 0;
        return e;
    endfunction

    // Drive one accepted strobe (called at a negedge) and queue its expectation.
    task automatic drive(input int which, input int md, input int sa, input int sb,
                         input int en, input logic [63:0] lp, input logic [63:0] rp);
        exp_t e;
        mode  = 2'(md);
        sel_a = 2'(sa);
        sel_b = 2'(sb);
        ch_en = 4'(en);
        l_in  = lp;
        r_in  = rp;
        e = model(which, md, sa, sb, en, lp, rp, vol_in);
        e.due = cyc + which + 1;
        if (which == 2) begin ce2 = 1'b1; q2.push_back(e); end
        else            begin ce4 = 1'b1; q4.push_back(e); end
        @(negedge clk);
        ce2 = 1'b0;
        ce4 = 1'b0;
    endtask

    task automatic drain(input string tag);
        int pending;
        for (int i = 0; i < 60 && (q2.size() != 0 || q4.size() != 0 || busy2 || busy4); i++)
            @(negedge clk);
        pending = q2.size() + q4.size() + int'(busy2) + int'(busy4);
        check_val(tag, pending, 0);
    endtask

    // Scoreboard: every out_valid pops one expectation and checks data and latency.
    always @(negedge clk) begin
        if (ov2) begin
            nv2++;
            if (q2.size() == 0) check_val("spurious_valid_n2", 1, 0);
            else begin
                m2 = q2.pop_front();
                check_val("n2_l", int'(a_l2), m2.l);
                check_val("n2_r", int'(a_r2), m2.r);
                check_val("n2_latency", cyc, m2.due);
            end
        end
        if (ov4) begin
            nv4++;
            if (q4.size() == 0) check_val("spurious_valid_n4", 1, 0);
            else begin
                m4 = q4.pop_front();
                check_val("n4_l", int'(a_l4), m4.l);
                check_val("n4_r", int'(a_r4), m4.r);
                check_val("n4_latency", cyc, m4.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   v0;
        exp_t e;
        rst = 1'b1; ce2 = 1'b0; ce4 = 1'b0; mode = '0; sel_a = '0; sel_b = '0;
        ch_en = '0; l_in = '0; r_in = '0; vol_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_audio_l", int'(a_l2), 0);
        check_val("rst_audio_r", int'(a_r2), 0);
        check_val("rst_out_valid", int'(ov2), 0);
        check_val("rst_busy", int'(busy2), 0);
        check_val("rst_overrun", int'(orun2), 0);
        // Strobe coincident with reset must be ignored.
        ce2 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce2 = 1'b0;
        @(negedge clk);
        check_val("ce_with_reset_ignored", int'(busy2), 0);

        // Saturating mix.
        drive(2, 2, 0, 0, 3, {32'h0, 16'h8000, 16'hC000}, {32'h0, 16'h0200, 16'h0100});
        check_val("busy_after_ce", int'(busy2), 1);
        drain("drain_sat");
        check_val("sat_l", int'(a_l2), 'hFFFF);
        check_val("sat_r", int'(a_r2), 'h0300);

        // Averaged mix, all enabled then none enabled.
        drive(4, 3, 0, 0, 15, {4{16'h4000}}, {4{16'h1000}});
        drain("drain_avg");
        check_val("avg_l", int'(a_l4), 'h4000);
        check_val("avg_r", int'(a_r4), 'h1000);
        drive(4, 3, 0, 0, 0, {4{16'h4000}}, {4{16'h1000}});
        drain("drain_avg0");
        check_val("avg_none_l", int'(a_l4), 0);
        check_val("avg_none_r", int'(a_r4), 0);

        // Split.
        drive(2, 1, 0, 1, 0, {32'h0, 16'hFFFF, 16'h2000}, {32'h0, 16'hFFFF, 16'h4000});
        drain("drain_split");
        check_val("split_l", int'(a_l2), 'h3000);
        check_val("split_r", int'(a_r2), 'hFFFF);
        repeat (4) @(negedge clk);
        check_val("hold_l", int'(a_l2), 'h3000);

        // Random patterns on both instances.
        for (int k = 0; k < 10; k++) begin
            int which;
            which = (k % 2 == 1) ? 4 : 2;
            drive(which, int'($urandom_range(0, 3)), int'($urandom_range(0, which - 1)),
                  int'($urandom_range(0, which - 1)), int'($urandom_range(0, 15)) & ((1 << which) - 1),
                  {$urandom, $urandom}, {$urandom, $urandom});
            drain("drain_rand");
        end

        // Back-to-back strobe: overrun, one result, snapshot isolation.
        v0 = nv2;
        mode = 2'd0; sel_a = 2'd1; sel_b = 2'd0; ch_en = 4'd0;
        l_in = {32'h0, 16'h1234, 16'h5678};
        r_in = {32'h0, 16'h9ABC, 16'hDEF0};
        e = model(2, 0, 1, 0, 0, l_in, r_in, vol_in);
        e.due = cyc + 3;
        q2.push_back(e);
        ce2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ce2 = 1'b0;
        l_in = {$urandom, $urandom};
        r_in = {$urandom, $urandom};
        sel_a = 2'd0;
        mode = 2'd2;
        drain("drain_overrun");
        check_val("overrun_set", int'(orun2), 1);
        check_val("one_valid", nv2 - v0, 1);
        check_val("solo_l", int'(a_l2), 'h1234);
        check_val("solo_r", int'(a_r2), 'h9ABC);

        // Reset mid-ACCUM aborts the mix.
        drive(2, 2, 0, 0, 3, {32'h0, 16'h0011, 16'h0022}, {32'h0, 16'h0033, 16'h0044});
        void'(q2.pop_back());
        rst = 1'b1;
        ce2 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce2 = 1'b0;
        check_val("abort_busy", int'(busy2), 0);
        check_val("abort_overrun", int'(orun2), 0);
        check_val("abort_l", int'(a_l2), 0);
        check_val("abort_r", int'(a_r2), 0);
        repeat (5) @(negedge clk);
        drive(2, 0, 0, 1, 0, {32'h0, 16'hAAAA, 16'h5555}, {32'h0, 16'hBBBB, 16'h6666});
        drain("drain_after_reset");

        // Maximum strobe rate: one strobe every N+2 cycles, no overrun.
        drive(2, 3, 0, 0, 3, {32'h0, 16'h0100, 16'h0300}, {32'h0, 16'h0002, 16'h0004});
        repeat (3) @(negedge clk);
        drive(2, 2, 0, 0, 1, {32'h0, 16'h0100, 16'h0300}, {32'h0, 16'h0002, 16'h0004});
        drain("drain_maxrate");
        check_val("maxrate_no_overrun", int'(orun2), 0);

`ifdef GB_MIX_VOLUME_EN
        vol_in = 16'h0021;
        drive(2, 2, 0, 0, 3, {32'h0, 16'h8000, 16'h8000}, 64'h0);
        drain("drain_vol");
        check_val("vol_l", int'(a_l2), 'h6000);
        vol_in = 16'h0000;
`endif

        check_val("queues_empty", q2.size() + q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
